// File: rtl/idct_pkg.sv
// Shared constants, bank-state encoding and small helpers for the IDCT pixel buffer.
package idct_pkg;

  localparam int unsigned BLK_PIX = 64;
  localparam int unsigned BLK_DIM = 8;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned IDCT_W  = 32;
  localparam int unsigned ADDR_W  = $clog2(BLK_PIX);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // t is IDCT bits [15:8] taken as signed; negatives clamp to zero.
  function automatic logic [PIX_W-1:0] clamp_pix(input logic [PIX_W-1:0] t);
    return t[PIX_W-1] ? '0 : t;
  endfunction

  // Raster index j -> column-major storage address (j%8)*8 + j/8.
  function automatic logic [ADDR_W-1:0] raster_addr(input logic [ADDR_W-1:0] j);
    return {j[2:0], j[5:3]};
  endfunction

endpackage

// File: rtl/pixel_bank_ram.sv
// One 64x8 pixel bank: synchronous write, combinational read.
module pixel_bank_ram
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem_q [BLK_PIX];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/idct_pixel_buffer.sv
// Ping-pong transpose buffer: column-major IDCT results in, clamped raster pixels out.
module idct_pixel_buffer #(
  parameter int unsigned BLK_PIX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_pixel,
  output logic               out_sof,
  output logic               out_last
);

  import idct_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_PIX - 1);

  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [PIX_W-1:0]  out_pixel_q, out_pixel_d;
  logic              out_sof_q, out_sof_d;
  logic              out_last_q, out_last_d;

  logic              in_hs;
  logic              rd_avail;
  logic              load;
  logic [PIX_W-1:0]  wr_pix;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rdata0, rdata1;
  logic              unused_in_bits;

  assign unused_in_bits = ^{in_data[31:16], in_data[7:0]};

  assign in_hs    = in_valid && in_ready_q;
  assign wr_pix   = clamp_pix(in_data[15:8]);
  assign rd_addr  = raster_addr(rd_cnt_q);
  assign rd_avail = (bank_q[rd_sel_q] == BANK_FULL) || (bank_q[rd_sel_q] == BANK_DRAINING);
  assign load     = rd_avail && (!out_valid_q || out_ready);

  pixel_bank_ram u_ram0 (
    .clk     (clk),
    .we_i    (in_hs && !wr_sel_q),
    .waddr_i (wr_cnt_q),
    .wdata_i (wr_pix),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  pixel_bank_ram u_ram1 (
    .clk     (clk),
    .we_i    (in_hs && wr_sel_q),
    .waddr_i (wr_cnt_q),
    .wdata_i (wr_pix),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_sof_d   = out_sof_q;
    out_last_d  = out_last_q;

    if (in_hs) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST_IDX) begin
        bank_d[wr_sel_q] = BANK_FULL;
        wr_sel_d         = !wr_sel_q;
      end else begin
        bank_d[wr_sel_q] = BANK_FILLING;
      end
    end

    // The bank is released once its last pixel sits in the output register,
    // so a refill overlaps the final handshake and streaming has no bubble.
    if (load) begin
      out_valid_d = 1'b1;
      out_pixel_d = rd_sel_q ? rdata1 : rdata0;
      out_sof_d   = (rd_cnt_q == '0);
      out_last_d  = (rd_cnt_q == LAST_IDX);
      rd_cnt_d    = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST_IDX) begin
        bank_d[rd_sel_q] = BANK_EMPTY;
        rd_sel_d         = !rd_sel_q;
      end else begin
        bank_d[rd_sel_q] = BANK_DRAINING;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_last_d  = 1'b0;
    end

    in_ready_d = (bank_d[wr_sel_d] == BANK_EMPTY) || (bank_d[wr_sel_d] == BANK_FILLING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_sof   = out_sof_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_idct_pixel_buffer.sv
// Directed bench for idct_pixel_buffer with a transpose/clamp scoreboard.
`timescale 1ns/1ps
module tb_idct_pixel_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pixel;
  logic        out_sof;
  logic        out_last;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, acc_cnt = 0, out_cnt = 0, in_k = 0, out_j = 0, mode = 0;
  int last_full_cyc = -1, first_val_cyc = -1;
  int first_out_cyc = -1, last_out_cyc = -1, ready_drops = 0;
  logic [7:0] blk_pix [64];
  logic [7:0] got [64];
  logic [7:0] exp_q [$];

  idct_pixel_buffer #(.BLK_PIX(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_last  (out_last)
  );

  function automatic logic [7:0] ref_clamp(input logic [7:0] t);
    return ($signed(t) < 0) ? 8'd0 : t;
  endfunction

  function automatic logic [31:0] gen(input int m, input int idx, input int k);
    logic [31:0] v;
    case (m)
      0: v = 32'(k) << 8;
      1: begin
        case (k)
          0:       v = 32'h00007F00;
          1:       v = 32'h00008000;
          2:       v = 32'hFFFFFF00;
          3:       v = 32'h12345600;
          4:       v = 32'h000000FF;
          default: v = 32'h0;
        endcase
      end
      default: v = (32'(idx) * 32'h9E3779B1) ^ (32'(idx) << 11);
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic       ihs, ohs, stall;
    logic [7:0] h_pix;
    logic       h_sof, h_last;
    ihs    = in_valid && in_ready;
    ohs    = out_valid && out_ready;
    stall  = out_valid && !out_ready && rst_n;
    h_pix  = out_pixel;
    h_sof  = out_sof;
    h_last = out_last;
    if (in_valid && !in_ready) ready_drops++;
    if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (!out_valid) begin
      chk("sof_idle", 32'(out_sof), 32'd0);
      chk("last_idle", 32'(out_last), 32'd0);
    end
    if (ohs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        chk("pixel", 32'(out_pixel), 32'(exp_q.pop_front()));
        chk("sof", 32'(out_sof), 32'(out_j == 0));
        chk("last", 32'(out_last), 32'(out_j == 63));
        got[out_j] = out_pixel;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_j = (out_j + 1) % 64;
        out_cnt++;
      end
    end
    if (ihs) begin
      blk_pix[in_k] = ref_clamp(in_data[15:8]);
      in_k++;
      acc_cnt++;
      if (in_k == 64) begin
        for (int j = 0; j < 64; j++) exp_q.push_back(blk_pix[(j % 8) * 8 + j / 8]);
        in_k = 0;
        last_full_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    in_data = gen(mode, acc_cnt, in_k);
    if (stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pixel", 32'(out_pixel), 32'(h_pix));
      chk("hold_sof", 32'(out_sof), 32'(h_sof));
      chk("hold_last", 32'(out_last), 32'(h_last));
    end
  endtask

  task automatic feed(input int n, input int budget);
    int goal;
    int b;
    goal = acc_cnt + n;
    b = 0;
    in_valid = 1'b1;
    in_data = gen(mode, acc_cnt, in_k);
    while (acc_cnt < goal && b < budget) begin
      step();
      b++;
    end
    in_valid = 1'b0;
    chk("feed_accepted", 32'(acc_cnt), 32'(goal));
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || out_valid) && b < budget) begin
      step();
      b++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base_in;
    int base_out;
    int goal;
    int b;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // One block k<<8: transpose, flags, N+2 latency
    mode = 0;
    out_ready = 1'b1;
    first_val_cyc = -1;
    feed(64, 200);
    drain(300);
    chk("latency", 32'(first_val_cyc - last_full_cyc), 32'd2);
    for (int j = 0; j < 64; j++) chk("raster_order", 32'(got[j]), 32'((j % 8) * 8 + j / 8));

    // Clamp vectors in column 0, rows 0..4
    mode = 1;
    feed(64, 200);
    drain(300);
    chk("clamp_7F00", 32'(got[0]), 32'd127);
    chk("clamp_8000", 32'(got[8]), 32'd0);
    chk("clamp_FFFFFF00", 32'(got[16]), 32'd0);
    chk("clamp_12345600", 32'(got[24]), 32'h56);
    chk("clamp_000000FF", 32'(got[32]), 32'd0);

    // Backpressure: both banks fill then inputs are held off
    mode = 2;
    out_ready = 1'b0;
    base_in = acc_cnt;
    in_valid = 1'b1;
    in_data = gen(mode, acc_cnt, in_k);
    repeat (200) step();
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc_cnt - base_in), 32'd128);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    base_out = out_cnt;
    drain(400);
    chk("bp_drained", 32'(out_cnt - base_out), 32'd128);

    // Streaming: four blocks back to back
    out_ready = 1'b1;
    ready_drops = 0;
    first_out_cyc = -1;
    base_out = out_cnt;
    feed(256, 400);
    drain(300);
    chk("stream_count", 32'(out_cnt - base_out), 32'd256);
    chk("stream_no_bubble", 32'(last_out_cyc - first_out_cyc), 32'd255);
    chk("stream_ready_drops", 32'(ready_drops), 32'd0);

    // Random valid/ready over 20 blocks
    base_out = out_cnt;
    goal = acc_cnt + 20 * 64;
    b = 0;
    while ((acc_cnt < goal || exp_q.size() > 0 || out_valid) && b < 20000) begin
      in_valid = (acc_cnt < goal) && ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      step();
      b++;
    end
    in_valid = 1'b0;
    chk("rand_out_count", 32'(out_cnt - base_out), 32'd1280);

    // Reset after 30 inputs of the second block
    out_ready = 1'b1;
    feed(64, 200);
    feed(30, 100);
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    in_k = 0;
    out_j = 0;
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready_after", 32'(in_ready), 32'd1);
    mode = 0;
    base_out = out_cnt;
    feed(64, 200);
    drain(300);
    chk("mid_rst_block_count", 32'(out_cnt - base_out), 32'd64);
    for (int j = 0; j < 64; j++) chk("mid_rst_raster", 32'(got[j]), 32'((j % 8) * 8 + j / 8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
